// File: rtl/bcd_7seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan: active-low segment
// codes ({g,f,e,d,c,b,a}), the all-anodes-off pattern and the digit count.
package bcd_7seg_pkg;

  localparam int NDIG = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [NDIG-1:0] ANODES_OFF = 4'hF;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes
// (10..15) show a dash so a corrupted digit is visible on the display.
module bcd_to_7seg
  import bcd_7seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed 4-digit common-anode scan with per-frame digit snapshot
// and a blank cycle per slot. Define BCD_7SEG_LZB_EN for leading-zero blanking.
module bcd_7seg_scan
  import bcd_7seg_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int CW       = $clog2(PRESCALE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd4,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          drive_q, drive_d;
  logic [3:0]    snap_q [NDIG];
  logic [3:0]    snap_d [NDIG];
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;

  logic          tick;
  logic          wrap;
  logic          blank_cur;
  logic [6:0]    dec_seg;

  assign tick = en && (cnt_q == CW'(PRESCALE - 1));
  assign wrap = (idx_q == 2'd3) || !valid_q;

  bcd_to_7seg u_dec (
    .bcd_i (snap_q[idx_q]),
    .seg_o (dec_seg)
  );

`ifdef BCD_7SEG_LZB_EN
  // Blank the current slot if it and every more-significant digit are zero.
  always_comb begin
    blank_cur = (idx_q != 2'd0);
    for (int k = 0; k < NDIG; k++) begin
      if (k >= int'(idx_q) && snap_q[k] != 4'd0) blank_cur = 1'b0;
    end
  end
`else
  assign blank_cur = 1'b0;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    drive_d = drive_q;
    snap_d  = snap_q;
    an_d    = an_q;
    seg_d   = seg_q;
    frame_d = 1'b0;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        if (wrap) begin
          idx_d   = 2'd0;
          snap_d  = '{bcd1, bcd2, bcd3, bcd4};
          frame_d = 1'b1;
        end else begin
          idx_d = idx_q + 2'd1;
        end
        valid_d = 1'b1;
        drive_d = 1'b1;
        an_d    = ANODES_OFF;
        seg_d   = SEG_BLANK;
      end else if (drive_q) begin
        // Drive edge: light the slot selected on the preceding tick.
        drive_d = 1'b0;
        if (blank_cur) begin
          an_d  = ANODES_OFF;
          seg_d = SEG_BLANK;
        end else begin
          an_d  = ~(4'b0001 << idx_q);
          seg_d = dec_seg;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
      drive_q <= 1'b0;
      snap_q  <= '{default: 4'd0};
      an_q    <= ANODES_OFF;
      seg_q   <= SEG_BLANK;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      drive_q <= drive_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Bench for bcd_7seg_scan with PRESCALE=4: table vectors, hand-written
// corner sequences and a randomized run against a counting reference model.
module tb_bcd_7seg_scan;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] bcd1 = '0, bcd2 = '0, bcd3 = '0, bcd4 = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame;

  int  errors = 0;
  int  checks = 0;
  bit  chk_on = 1'b0;

  bcd_7seg_scan #(.PRESCALE(P)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .bcd1  (bcd1),
    .bcd2  (bcd2),
    .bcd3  (bcd3),
    .bcd4  (bcd4),
    .an    (an),
    .seg   (seg),
    .frame (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts enabled edges since reset; every P-th enabled
  // edge is a slot boundary, slot number modulo 4 is the digit position.
  logic [6:0] seg_lut [16];
  logic [3:0] snap [4];
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_frame;
  int         ecnt;
  int         cur;

  function automatic bit lzb(input int p);
`ifdef BCD_7SEG_LZB_EN
    if (p == 0) return 1'b0;
    for (int k = p; k < 4; k++) if (snap[k] != 4'd0) return 1'b0;
    return 1'b1;
`else
    return (p < 0);
`endif
  endfunction

  always @(posedge clk or negedge rst) begin : model
    int e;
    int c;
    if (!rst) begin
      ecnt    <= 0;
      cur     <= 0;
      snap    <= '{default: 4'd0};
      m_an    <= 4'hF;
      m_seg   <= 7'h7F;
      m_frame <= 1'b0;
    end else begin
      m_frame <= 1'b0;
      if (en) begin
        e = ecnt + 1;
        ecnt <= e;
        if (e % P == 0) begin
          c = (e / P - 1) % 4;
          cur <= c;
          if (c == 0) begin
            snap    <= '{bcd1, bcd2, bcd3, bcd4};
            m_frame <= 1'b1;
          end
          m_an  <= 4'hF;
          m_seg <= 7'h7F;
        end else if (e % P == 1 && e > P) begin
          if (lzb(cur)) begin
            m_an  <= 4'hF;
            m_seg <= 7'h7F;
          end else begin
            m_an  <= ~(4'b0001 << cur);
            m_seg <= seg_lut[snap[cur]];
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      check("model_an", 32'(an), 32'(m_an));
      check("model_seg", 32'(seg), 32'(m_seg));
      check("model_frame", 32'(frame), 32'(m_frame));
    end
  end

  typedef struct {
    logic [15:0] digits;  // {bcd4,bcd3,bcd2,bcd1}
    logic [15:0] ans;     // expected an per slot {s3,s2,s1,s0}
    logic [27:0] segs;    // expected seg per slot {s3,s2,s1,s0}
  } vec_t;

  vec_t vecs [5];

  task automatic set_digits(input logic [15:0] d);
    {bcd4, bcd3, bcd2, bcd1} = d;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (frame !== 1'b1 && n < 40);
    check("frame_seen", 32'(frame), 32'd1);
  endtask

  task automatic sample();
    @(posedge clk); #2;
  endtask

  initial begin
    logic [3:0] d [4];
    for (int i = 0; i < 16; i++) seg_lut[i] = 7'h3F;
    seg_lut[0] = 7'h40; seg_lut[1] = 7'h79; seg_lut[2] = 7'h24; seg_lut[3] = 7'h30;
    seg_lut[4] = 7'h19; seg_lut[5] = 7'h12; seg_lut[6] = 7'h02; seg_lut[7] = 7'h78;
    seg_lut[8] = 7'h00; seg_lut[9] = 7'h10;

    vecs[0] = '{16'h1234, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'h9876, 16'h7BDE, {7'h10, 7'h00, 7'h78, 7'h02}};
    vecs[2] = '{16'h50CF, 16'h7BDE, {7'h12, 7'h40, 7'h3F, 7'h3F}};
`ifdef BCD_7SEG_LZB_EN
    vecs[3] = '{16'h0007, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
    vecs[4] = '{16'h0300, 16'hFBDE, {7'h7F, 7'h30, 7'h40, 7'h40}};
`else
    vecs[3] = '{16'h0007, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h78}};
    vecs[4] = '{16'h0300, 16'h7BDE, {7'h40, 7'h30, 7'h40, 7'h40}};
`endif

    // Reset state and first-frame timing with digits 1,2,3,4.
    #1 rst = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_frame", 32'(frame), 32'd0);
    set_digits(16'h1234);
    en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    chk_on = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      sample();
      check("first_tick_frame", 32'(frame), 32'(e == 4));
      check("first_tick_an", 32'(an), 32'hF);
    end
    check("first_blank_seg", 32'(seg), 32'h7F);
    for (int e = 5; e <= 7; e++) begin
      sample();
      check("slot0_an", 32'(an), 32'hE);
      check("slot0_seg", 32'(seg), 32'h19);
    end
    sample();
    check("slot1_blank_an", 32'(an), 32'hF);
    check("slot1_blank_frame", 32'(frame), 32'd0);
    sample();
    check("slot1_an", 32'(an), 32'hD);
    check("slot1_seg", 32'(seg), 32'h30);

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_digits(vecs[i].digits);
      wait_frame();
      check("vec_blank_an", 32'(an), 32'hF);
      for (int p = 0; p < 4; p++) begin
        if (p != 0) repeat (3) @(posedge clk);
        sample();
        check($sformatf("vec%0d_an_s%0d", i, p), 32'(an), 32'(vecs[i].ans[p*4 +: 4]));
        check($sformatf("vec%0d_seg_s%0d", i, p), 32'(seg), 32'(vecs[i].segs[p*7 +: 7]));
      end
    end

    // Mid-frame input change is ignored until the next snapshot.
    @(negedge clk);
    set_digits(16'h1234);
    wait_frame();
    sample();
    @(negedge clk);
    bcd1 = 4'd9;
    for (int k = 0; k < 2; k++) begin
      sample();
      check("hold_snap_seg", 32'(seg), 32'h19);
    end
    wait_frame();
    sample();
    check("new_snap_an", 32'(an), 32'hE);
    check("new_snap_seg", 32'(seg), 32'h10);

    // Enable dropped for 10 cycles during a lit slot.
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sample();
      check("freeze_an", 32'(an), 32'hE);
      check("freeze_seg", 32'(seg), 32'h10);
      check("freeze_frame", 32'(frame), 32'd0);
    end
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sample();
      check("resume_lit_an", 32'(an), 32'hE);
    end
    sample();
    check("resume_tick_an", 32'(an), 32'hF);
    check("resume_tick_frame", 32'(frame), 32'd0);

    // Asynchronous reset mid-scan, then first tick P enabled cycles later.
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_seg", 32'(seg), 32'h7F);
    check("async_rst_frame", 32'(frame), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      sample();
      check("post_rst_frame", 32'(frame), 32'(e == 4));
    end

    // Randomized run against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 4; k++)
          d[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        {bcd4, bcd3, bcd2, bcd1} = {d[3], d[2], d[1], d[0]};
      end
      if ($urandom_range(0, 299) == 0) begin
        #3 rst = 1'b0;
        #1;
        check("rand_rst_an", 32'(an), 32'hF);
        check("rand_rst_seg", 32'(seg), 32'h7F);
        @(negedge clk);
        rst = 1'b1;
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
